floor_request_scheduler: RTL and testbench

//  Parametrised successor to the 3-bit floor comparator: a sequential SCAN scheduler for one car.

---
 rtl/floor_req_if.sv | 27 ++
 rtl/floor_request_scheduler.sv | 108 ++++++++++
 tb/tb_floor_request_scheduler.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/floor_req_if.sv
// Request/decision bundle between request decode, the floor scheduler and the motion controller.
// master drives the requests and the car position; slave is the scheduler that drives the decision outputs.
interface floor_req_if #(
  parameter int FLOORS = 8
);
  localparam int FLOOR_W = $clog2(FLOORS);

  logic               req_valid;
  logic [FLOOR_W-1:0] req_floor;
  logic [FLOOR_W-1:0] now_floor;
  logic               arrived;
  logic [1:0]         dir;
  logic [FLOOR_W-1:0] target;
  logic               target_valid;
  logic               stop_here;
  logic [FLOORS-1:0]  pending;

  modport master (
    output req_valid, req_floor, now_floor, arrived,
    input  dir, target, target_valid, stop_here, pending
  );

  modport slave (
    input  req_valid, req_floor, now_floor, arrived,
    output dir, target, target_valid, stop_here, pending
  );
endinterface

// File: rtl/floor_request_scheduler.sv
// SCAN scheduler for one car: latches floor requests into a pending bitmap and each cycle picks
// a travel direction plus the nearest pending target, with all decisions made on the updated bitmap.
module floor_request_scheduler #(
  parameter  int FLOORS  = 8,
  localparam int FLOOR_W = $clog2(FLOORS)
) (
  input  logic        clk,
  input  logic        rst_n,
  floor_req_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [FLOORS-1:0]  pending_q, pending_d;
  logic [FLOOR_W-1:0] target_q, target_d;
  logic               tvalid_q, tvalid_d;
  logic               stop_q, stop_d;

  logic               above, below, here;
  logic [FLOOR_W-1:0] up_tgt, dn_tgt;

  // Floor indices >= FLOORS never match a bit, so out-of-range requests and arrivals fall out naturally.
  // The clear is applied after the set so a same-cycle request at the car's floor counts as served.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < FLOORS; i++) begin
      if (bus.req_valid && (bus.req_floor == FLOOR_W'(i))) pending_d[i] = 1'b1;
      if (bus.arrived   && (bus.now_floor == FLOOR_W'(i))) pending_d[i] = 1'b0;
    end
  end

  always_comb begin
    above  = 1'b0;
    below  = 1'b0;
    here   = 1'b0;
    dn_tgt = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (pending_d[i]) begin
        if (FLOOR_W'(i) > bus.now_floor) above = 1'b1;
        if (FLOOR_W'(i) < bus.now_floor) begin
          below  = 1'b1;
          dn_tgt = FLOOR_W'(i);
        end
        if (FLOOR_W'(i) == bus.now_floor) here = 1'b1;
      end
    end
  end

  // Descending walk leaves the lowest pending floor above the car.
  always_comb begin
    up_tgt = '0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (pending_d[i] && (FLOOR_W'(i) > bus.now_floor)) up_tgt = FLOOR_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = bus.now_floor;
    unique case (state_q)
      DOWN: begin
        if (below)      state_d = DOWN;
        else if (above) state_d = UP;
        else            state_d = IDLE;
      end
      default: begin
        if (above)      state_d = UP;
        else if (below) state_d = DOWN;
        else            state_d = IDLE;
      end
    endcase
    unique case (state_d)
      UP:      target_d = up_tgt;
      DOWN:    target_d = dn_tgt;
      default: target_d = bus.now_floor;
    endcase
    tvalid_d = (state_d != IDLE) | here;
    stop_d   = here & ~bus.arrived;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      target_q  <= '0;
      tvalid_q  <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      target_q  <= target_d;
      tvalid_q  <= tvalid_d;
      stop_q    <= stop_d;
    end
  end

  assign bus.dir          = state_q;
  assign bus.target       = target_q;
  assign bus.target_valid = tvalid_q;
  assign bus.stop_here    = stop_q;
  assign bus.pending      = pending_q;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Bench for floor_request_scheduler: an 8-floor and a 6-floor instance share one stimulus stream and are
// compared every cycle against a list-based SCAN model, with directed scenario checks layered on top.
module tb_floor_request_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  floor_req_if #(.FLOORS(8)) b8 ();
  floor_req_if #(.FLOORS(6)) b6 ();

  floor_request_scheduler #(.FLOORS(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  floor_request_scheduler #(.FLOORS(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(b6));

  int total = 0;
  int bad   = 0;

  bit rv;
  int rf, nf;
  bit arr;

  // Model state per instance: index 0 is the 8-floor car, index 1 the 6-floor car.
  logic [31:0] m_pend [2];
  int          m_st   [2];   // 0 idle, 1 up, 2 down
  int          e_tgt  [2];
  bit          e_tv   [2];
  bit          e_stop [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ed(input int s);
    return (s == 1) ? 2'b01 : (s == 2) ? 2'b10 : 2'b00;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = '0;
      m_st[k]   = 0;
      e_tgt[k]  = 0;
      e_tv[k]   = 1'b0;
      e_stop[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    int          n;
    logic [31:0] pn;
    bit          ab, be, hit;
    int          t;
    n  = (k == 0) ? 8 : 6;
    pn = m_pend[k];
    if (rv && rf < n)  pn[rf] = 1'b1;
    if (arr && nf < n) pn[nf] = 1'b0;
    ab = 1'b0;
    be = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (pn[i] && i > nf) ab = 1'b1;
      if (pn[i] && i < nf) be = 1'b1;
    end
    if (m_st[k] == 2) m_st[k] = be ? 2 : (ab ? 1 : 0);
    else              m_st[k] = ab ? 1 : (be ? 2 : 0);
    t = nf;
    if (m_st[k] == 1) begin
      t = -1;
      for (int i = nf + 1; i < n; i++) if (pn[i] && t < 0) t = i;
    end else if (m_st[k] == 2) begin
      for (int i = 0; i < n && i < nf; i++) if (pn[i]) t = i;
    end
    hit       = (nf < n) && pn[nf];
    e_tgt[k]  = t;
    e_tv[k]   = (m_st[k] != 0) || hit;
    e_stop[k] = hit && !arr;
    m_pend[k] = pn;
  endtask

  task automatic check_all();
    chk("dir8",    32'(b8.dir),          32'(ed(m_st[0])));
    chk("target8", 32'(b8.target),       32'(e_tgt[0]));
    chk("tvalid8", 32'(b8.target_valid), 32'(e_tv[0]));
    chk("stop8",   32'(b8.stop_here),    32'(e_stop[0]));
    chk("pend8",   32'(b8.pending),      32'(m_pend[0][7:0]));
    chk("dir6",    32'(b6.dir),          32'(ed(m_st[1])));
    chk("target6", 32'(b6.target),       32'(e_tgt[1]));
    chk("tvalid6", 32'(b6.target_valid), 32'(e_tv[1]));
    chk("stop6",   32'(b6.stop_here),    32'(e_stop[1]));
    chk("pend6",   32'(b6.pending),      32'(m_pend[1][5:0]));
  endtask

  task automatic drive(input bit v, input int f, input int now, input bit a);
    rv  = v;
    rf  = f;
    nf  = now;
    arr = a;
    b8.req_valid = v;  b8.req_floor = 3'(f);  b8.now_floor = 3'(now);  b8.arrived = a;
    b6.req_valid = v;  b6.req_floor = 3'(f);  b6.now_floor = 3'(now);  b6.arrived = a;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    drive(1'b0, 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    drive(1'b0, 0, 0, 1'b0);
    #12;
    chk("rst_dir",  32'(b8.dir),          32'h0);
    chk("rst_pend", 32'(b8.pending),      32'h0);
    chk("rst_tv",   32'(b8.target_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill every floor while parked at 0, then pull reset between edges.
    for (int f = 0; f < 8; f++) begin
      drive(1'b1, f, 0, 1'b0);
      cycle();
    end
    chk("s1_pend", 32'(b8.pending), 32'hFF);
    chk("s1_dir",  32'(b8.dir),     32'h1);
    drive(1'b0, 0, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s1_async_pend", 32'(b8.pending),      32'h0);
    chk("s1_async_dir",  32'(b8.dir),          32'h0);
    chk("s1_async_tgt",  32'(b8.target),       32'h0);
    chk("s1_async_tv",   32'(b8.target_valid), 32'h0);
    chk("s1_async_stop", 32'(b8.stop_here),    32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Nearer request above takes over the target while heading up.
    do_reset();
    drive(1'b1, 6, 2, 1'b0); cycle();
    chk("s2_dir", 32'(b8.dir), 32'h1);
    chk("s2_tgt", 32'(b8.target), 32'h6);
    chk("s2_tv",  32'(b8.target_valid), 32'h1);
    drive(1'b1, 4, 2, 1'b0); cycle();
    chk("s2_tgt_near", 32'(b8.target), 32'h4);
    chk("s2_dir_hold", 32'(b8.dir), 32'h1);

    // Reversal at the top of the run, then SCAN hold despite a new request above.
    do_reset();
    drive(1'b1, 5, 0, 1'b0); cycle();
    drive(1'b1, 1, 3, 1'b0); cycle();
    chk("s3_up", 32'(b8.dir), 32'h1);
    drive(1'b0, 0, 5, 1'b1); cycle();
    chk("s3_rev_dir",  32'(b8.dir), 32'h2);
    chk("s3_rev_tgt",  32'(b8.target), 32'h1);
    chk("s3_rev_pend", 32'(b8.pending), 32'h02);
    drive(1'b1, 7, 5, 1'b0); cycle();
    chk("s3_hold_dir", 32'(b8.dir), 32'h2);
    chk("s3_hold_tgt", 32'(b8.target), 32'h1);

    // Same-floor set and clear: clear wins.
    do_reset();
    drive(1'b1, 3, 3, 1'b1); cycle();
    chk("s4_pend", 32'(b8.pending), 32'h0);
    chk("s4_stop", 32'(b8.stop_here), 32'h0);
    chk("s4_dir",  32'(b8.dir), 32'h0);

    // Request at the current floor while idle, then served.
    drive(1'b1, 3, 3, 1'b0); cycle();
    chk("s5_dir",  32'(b8.dir), 32'h0);
    chk("s5_tgt",  32'(b8.target), 32'h3);
    chk("s5_tv",   32'(b8.target_valid), 32'h1);
    chk("s5_stop", 32'(b8.stop_here), 32'h1);
    drive(1'b0, 0, 3, 1'b1); cycle();
    chk("s5_clr_pend", 32'(b8.pending), 32'h0);
    chk("s5_clr_tv",   32'(b8.target_valid), 32'h0);

    // Bottom floor plus top floor; serve 0 and keep heading for 7.
    do_reset();
    drive(1'b1, 0, 0, 1'b0); cycle();
    drive(1'b1, 7, 0, 1'b0); cycle();
    chk("s6_dir", 32'(b8.dir), 32'h1);
    drive(1'b0, 0, 0, 1'b1); cycle();
    chk("s6_srv_dir",  32'(b8.dir), 32'h1);
    chk("s6_srv_tgt",  32'(b8.target), 32'h7);
    chk("s6_srv_pend", 32'(b8.pending), 32'h80);

    // Idle decision at 4 with {2,6} pending: tie favours up.
    do_reset();
    drive(1'b1, 2, 2, 1'b0); cycle();
    drive(1'b1, 6, 4, 1'b0); cycle();
    chk("s6_tie_dir", 32'(b8.dir), 32'h1);
    chk("s6_tie_tgt", 32'(b8.target), 32'h6);

    // Out-of-range floors on the 6-floor car.
    do_reset();
    drive(1'b1, 7, 0, 1'b0); cycle();
    chk("oor_req7_6",  32'(b6.pending), 32'h0);
    chk("oor_req7_8",  32'(b8.pending), 32'h80);
    drive(1'b1, 6, 0, 1'b0); cycle();
    chk("oor_req6_6",  32'(b6.pending), 32'h0);
    drive(1'b1, 2, 7, 1'b0); cycle();
    drive(1'b0, 0, 7, 1'b1); cycle();
    chk("oor_now_pend", 32'(b6.pending), 32'h04);
    chk("oor_now_dir",  32'(b6.dir), 32'h2);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
